// File: rtl/trb_mem_arbiter.sv
// trb_mem_arbiter: time-sliced trace memory shared between a logger and a host.
// Each period of TURN_DIV cycles has a LOG slot (count 0), a HOST slot
// (count 1) and IDLE slots. The logger reads when entering LOG and writes when
// leaving it. The host is served when leaving HOST.
// Optional feature macro: TRB_MEM_PARITY_EN stores an even-parity bit per word
// and flags mismatches on reads in a sticky parity_err_o.
//
// Host handshake: host_req_i is a request level that the host holds stable
// (with we/addr/wdata) until it sees host_ack_o. The request is sampled only
// on the edge leaving the HOST slot. host_ack_o is a one-cycle pulse that
// completes the transfer, and host_rdata_o is valid from the ack onward.
`ifndef TRB_DEPTH
`define TRB_DEPTH 16
`endif
`ifndef TRB_WIDTH
`define TRB_WIDTH 8
`endif

module trb_mem_arbiter #(
  parameter int DEPTH    = `TRB_DEPTH,
  parameter int WIDTH    = `TRB_WIDTH,
  parameter int TURN_DIV = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic                     rw_turn_o,
  input  logic                     write_i,
  output logic                     write_allow_o,
  output logic                     read_allow_o,
  input  logic [$clog2(DEPTH)-1:0] write_ptr_i,
  input  logic [$clog2(DEPTH)-1:0] read_ptr_i,
  input  logic [WIDTH-1:0]         dmem_i,
  output logic [WIDTH-1:0]         dmem_o,
  input  logic                     host_lock_i,
  input  logic                     host_req_i,
  input  logic                     host_we_i,
  input  logic [$clog2(DEPTH)-1:0] host_addr_i,
  input  logic [WIDTH-1:0]         host_wdata_i,
  output logic                     host_ack_o,
  output logic [WIDTH-1:0]         host_rdata_o,
  output logic                     parity_err_o,
  output logic [1:0]               dbg_state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TURN_DIV);
  localparam logic [CW-1:0] LAST = CW'(TURN_DIV - 1);
`ifdef TRB_MEM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  typedef enum logic [1:0] {ST_LOG = 2'd0, ST_HOST = 2'd1, ST_IDLE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              run_q;
  logic              rw_turn_q, rw_turn_d;
  logic [WIDTH-1:0]  dmem_q, dmem_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              lock_q;
  logic [MW-1:0]     mem_q [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [MW-1:0]     rd_log_word, rd_host_word;
  logic              leave_log, leave_host, load_dmem, host_rd;

  // Pointers wider than the memory wrap back into range (ptr < 2*DEPTH).
  function automatic logic [AW-1:0] wrap(input logic [AW-1:0] p);
    if ({1'b0, p} >= (AW+1)'(DEPTH)) return AW'({1'b0, p} - (AW+1)'(DEPTH));
    return p;
  endfunction

  assign rd_log_word  = mem_q[wrap(read_ptr_i)];
  assign rd_host_word = mem_q[wrap(host_addr_i)];

  // Slot sequencing, memory access decisions and next values of all outputs.
  // run_q holds the counter at 0 for the first edge so that the first cycle
  // after that edge is a full LOG slot with the strobe already registered.
  always_comb begin
    cnt_d     = cnt_q;
    state_d   = state_q;
    rw_turn_d = 1'b0;
    dmem_d    = dmem_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!run_q || cnt_q == LAST) cnt_d = '0;
    else                         cnt_d = cnt_q + CW'(1);
    if (cnt_d == '0)             state_d = ST_LOG;
    else if (cnt_d == CW'(1))    state_d = ST_HOST;
    else                         state_d = ST_IDLE;
    rw_turn_d  = (state_d == ST_LOG);
    load_dmem  = (state_d == ST_LOG);
    leave_log  = run_q && (state_q == ST_LOG);
    leave_host = run_q && (state_q == ST_HOST);
    host_rd    = leave_host && host_req_i && !host_we_i;
    if (load_dmem) dmem_d = rd_log_word[WIDTH-1:0];
    if (leave_host && host_req_i) ack_d = 1'b1;
    if (host_rd) rdata_d = rd_host_word[WIDTH-1:0];
    if (leave_log && write_i && !lock_q) begin
      mem_we    = 1'b1;
      mem_waddr = wrap(write_ptr_i);
      mem_wdata = dmem_i;
    end else if (leave_host && host_req_i && host_we_i && lock_q) begin
      mem_we    = 1'b1;
      mem_waddr = wrap(host_addr_i);
      mem_wdata = host_wdata_i;
    end
  end

  // State and output registers; asynchronous reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_LOG;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      rw_turn_q <= 1'b0;
      dmem_q    <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_q     <= 1'b1;
      rw_turn_q <= rw_turn_d;
      dmem_q    <= dmem_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      lock_q    <= host_lock_i;
    end
  end

  // Memory array is not reset; writes are gated by run_q which clears at once.
  always_ff @(posedge clk_i) begin
`ifdef TRB_MEM_PARITY_EN
    if (mem_we) mem_q[mem_waddr] <= {^mem_wdata, mem_wdata};
`else
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
`endif
  end

`ifdef TRB_MEM_PARITY_EN
  logic perr_q;
  // Sticky parity flag: any logger or host read of a word with odd parity.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perr_q <= 1'b0;
    else if ((load_dmem && (^rd_log_word)) || (host_rd && (^rd_host_word))) perr_q <= 1'b1;
  end
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign rw_turn_o     = rw_turn_q;
  assign dmem_o        = dmem_q;
  assign host_rdata_o  = rdata_q;
  assign host_ack_o    = ack_q;
  assign write_allow_o = !lock_q;
  assign read_allow_o  = !lock_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_trb_mem_arbiter.sv
// Testbench for trb_mem_arbiter: directed slot/lock/host scenarios followed by
// random traffic, all checked every cycle against a period/phase reference model.
module tb_trb_mem_arbiter;
  localparam int DEPTH = 16, WIDTH = 8, TURN_DIV = 4, AW = 4;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             rw_turn_o, write_allow_o, read_allow_o, host_ack_o, parity_err_o;
  logic             write_i, host_lock_i, host_req_i, host_we_i;
  logic [AW-1:0]    write_ptr_i, read_ptr_i, host_addr_i;
  logic [WIDTH-1:0] dmem_i, dmem_o, host_wdata_i, host_rdata_o;
  logic [1:0]       dbg_state_o;

  int checks = 0, errors = 0;

  trb_mem_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TURN_DIV(TURN_DIV)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rw_turn_o(rw_turn_o), .write_i(write_i),
    .write_allow_o(write_allow_o), .read_allow_o(read_allow_o),
    .write_ptr_i(write_ptr_i), .read_ptr_i(read_ptr_i), .dmem_i(dmem_i), .dmem_o(dmem_o),
    .host_lock_i(host_lock_i), .host_req_i(host_req_i), .host_we_i(host_we_i),
    .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i), .host_ack_o(host_ack_o),
    .host_rdata_o(host_rdata_o), .parity_err_o(parity_err_o), .dbg_state_o(dbg_state_o)
  );

  // clock / watchdog
  initial forever #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // e counts edges since reset release; the cycle after edge n is phase (n-1)%TURN_DIV.
  int               e = 0;
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_v   [DEPTH];
  logic             m_lock = 1'b0;
  logic             exp_turn, exp_ack;
  logic [WIDTH-1:0] exp_dmem, exp_rdata;
  bit               exp_dmem_v, exp_rdata_v;
  bit               exp_par = 1'b0, par_skip = 1'b0;

  initial begin
    int pb, pa;
    bit srv;
    logic [WIDTH-1:0] rd_l, rd_h;
    bit rd_lv, rd_hv;
    foreach (m_v[i]) m_v[i] = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e = 0; m_lock = 1'b0; exp_turn = 1'b0; exp_ack = 1'b0;
        exp_dmem = '0; exp_dmem_v = 1'b1; exp_rdata = '0; exp_rdata_v = 1'b1;
      end else begin
        pb = (e == 0) ? -1 : (e - 1) % TURN_DIV;   // phase before this edge
        pa = e % TURN_DIV;                          // phase after this edge
        e++;
        rd_l = m_mem[read_ptr_i];  rd_lv = m_v[read_ptr_i];
        rd_h = m_mem[host_addr_i]; rd_hv = m_v[host_addr_i];
        srv = (pb == 1) && host_req_i;
        exp_ack = srv;
        if (srv && !host_we_i) begin exp_rdata = rd_h; exp_rdata_v = rd_hv; end
        if (pa == 0) begin exp_dmem = rd_l; exp_dmem_v = rd_lv; end
        if (pb == 0 && write_i && !m_lock) begin
          m_mem[write_ptr_i] = dmem_i; m_v[write_ptr_i] = 1'b1;
        end
        if (srv && host_we_i && m_lock) begin
          m_mem[host_addr_i] = host_wdata_i; m_v[host_addr_i] = 1'b1;
        end
        exp_turn = (pa == 0);
        m_lock = host_lock_i;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(posedge clk); #2;
    if (rst_n && e > 0) begin
      chk("rw_turn", rw_turn_o, exp_turn);
      chk("host_ack", host_ack_o, exp_ack);
      chk("write_allow", write_allow_o, !m_lock);
      chk("read_allow", read_allow_o, !m_lock);
      if (exp_dmem_v)  chk("dmem", dmem_o, exp_dmem);
      if (exp_rdata_v) chk("host_rdata", host_rdata_o, exp_rdata);
      if (!par_skip)   chk("parity_err", parity_err_o, exp_par);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic goto_phase(input int p);
    for (int i = 0; i <= TURN_DIV; i++) begin
      @(negedge clk);
      if (e > 0 && ((e - 1) % TURN_DIV) == p) return;
    end
    checks++; errors++;
    $display("FAIL goto_phase: phase %0d not reached", p);
  endtask

  task automatic host_op(input bit we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                         output int lat);
    host_req_i = 1'b1; host_we_i = we; host_addr_i = a; host_wdata_i = d; lat = 0;
    for (int i = 1; i <= 3 * TURN_DIV; i++) begin
      @(negedge clk);
      if (host_ack_o) begin lat = i; break; end
    end
    host_req_i = 1'b0;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL host_ack_timeout: actual none required ack within %0d cycles", 3 * TURN_DIV);
    end
  endtask

  task automatic log_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    goto_phase(0);
    write_i = 1'b1; write_ptr_i = a; dmem_i = d;
    goto_phase(1);
    write_i = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int lat;
    write_i = 0; write_ptr_i = 0; read_ptr_i = 0; dmem_i = 0;
    host_lock_i = 0; host_req_i = 0; host_we_i = 0; host_addr_i = 0; host_wdata_i = 0;
    repeat (3) @(negedge clk);
    chk("reset_rw_turn", rw_turn_o, 0);
    chk("reset_dmem", dmem_o, 0);
    chk("reset_rdata", host_rdata_o, 0);
    chk("reset_ack", host_ack_o, 0);
    chk("reset_write_allow", write_allow_o, 1);
    chk("reset_read_allow", read_allow_o, 1);
    chk("reset_parity", parity_err_o, 0);
    rst_n = 1'b1;

    // strobe in cycles 0,4,8 after release
    @(posedge clk); #1;
    chk("first_turn", rw_turn_o, 1);
    for (int i = 2; i <= 9; i++) begin
      @(posedge clk); #1;
      chk("turn_pattern", rw_turn_o, (i % 4) == 1);
    end

    // logger write then read back next period
    log_write(5, 8'hA5);
    read_ptr_i = 5;
    goto_phase(0);
    chk("log_read_addr5", dmem_o, 8'hA5);

    // same-address read/write in one period returns old data
    write_i = 1; write_ptr_i = 3; dmem_i = 8'h11;
    goto_phase(1); write_i = 0; read_ptr_i = 3;
    goto_phase(0);
    chk("same_addr_old", dmem_o, 8'h11);
    write_i = 1; write_ptr_i = 3; dmem_i = 8'h22;
    goto_phase(1); write_i = 0;
    goto_phase(0);
    chk("same_addr_new", dmem_o, 8'h22);

    // lock: allows drop, logger write dropped, host write/read take effect
    log_write(7, 8'h44);
    host_lock_i = 1;
    @(negedge clk);
    chk("lock_write_allow", write_allow_o, 0);
    chk("lock_read_allow", read_allow_o, 0);
    log_write(7, 8'h33);
    goto_phase(2);
    host_op(0, 7, 8'h00, lat);
    chk("locked_log_write_dropped", host_rdata_o, 8'h44);
    host_op(1, 7, 8'h5A, lat);
    chk("host_write_ack_latency", lat, 4);
    host_op(0, 7, 8'h00, lat);
    chk("host_read_after_write", host_rdata_o, 8'h5A);
    host_lock_i = 0;
    @(negedge clk);
    chk("unlock_allow", write_allow_o, 1);

    // request at count 2 acked 4 cycles later; unlocked host write ignored
    goto_phase(2);
    host_op(1, 7, 8'h77, lat);
    chk("req_at_2_latency", lat, 4);
    host_op(0, 7, 8'h00, lat);
    chk("unlocked_host_write_ignored", host_rdata_o, 8'h5A);

    // reset during a pending locked host write aborts it
    host_lock_i = 1;
    @(negedge clk);
    goto_phase(0);
    host_req_i = 1; host_we_i = 1; host_addr_i = 7; host_wdata_i = 8'hEE;
    @(negedge clk);
    rst_n = 0; host_req_i = 0; host_lock_i = 0;
    @(negedge clk);
    chk("abort_no_ack", host_ack_o, 0);
    chk("abort_reset_allow", write_allow_o, 1);
    rst_n = 1;
    goto_phase(2);
    host_op(0, 7, 8'h00, lat);
    chk("abort_no_write", host_rdata_o, 8'h5A);

    // random traffic, checked by the model every cycle
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      write_i     = 1'($urandom_range(0, 1));
      write_ptr_i = AW'($urandom_range(0, DEPTH - 1));
      read_ptr_i  = AW'($urandom_range(0, DEPTH - 1));
      dmem_i      = WIDTH'($urandom_range(0, 255));
      if (i % 40 == 0) host_lock_i = 1'($urandom_range(0, 1));
      if (host_req_i && host_ack_o) host_req_i = 0;
      else if (!host_req_i && $urandom_range(0, 2) == 0) begin
        host_req_i   = 1;
        host_we_i    = 1'($urandom_range(0, 1));
        host_addr_i  = AW'($urandom_range(0, DEPTH - 1));
        host_wdata_i = WIDTH'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    if (host_req_i && host_ack_o) host_req_i = 0;
    while (host_req_i) begin
      @(negedge clk);
      if (host_ack_o) host_req_i = 0;
    end
    write_i = 0; host_lock_i = 0;

`ifdef TRB_MEM_PARITY_EN
    // corrupted parity on word 2 is flagged by a host read and stays set
    read_ptr_i = 0;
    log_write(2, 8'hC3);
    dut.mem_q[2][WIDTH] = ~dut.mem_q[2][WIDTH];
    par_skip = 1;
    goto_phase(2);
    host_op(0, 2, 8'h00, lat);
    chk("parity_set", parity_err_o, 1);
    exp_par = 1; par_skip = 0;
    repeat (10) @(negedge clk);
    chk("parity_sticky", parity_err_o, 1);
    rst_n = 0;
    @(negedge clk);
    chk("parity_cleared", parity_err_o, 0);
    exp_par = 0;
    rst_n = 1;
    repeat (4) @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trb_mem_arbiter.md
TRB_MEM_ARBITER -- requirements
Module: trb_mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default TRB_DEPTH, number of trace memory words.
REQ-002 SHALL have parameter WIDTH, default TRB_WIDTH, bits per word.
REQ-003 SHALL have parameter TURN_DIV, default 4, slot period in cycles (legal range 2..16).
REQ-004 CLK_I  in  1  single clock; all state on rising edge.
REQ-005 RST_NI  in  1  reset, asynchronous, active-low.
REQ-006 RW_TURN_O  out  1  logger slot strobe.
REQ-007 WRITE_I  in  1  logger write intent.
REQ-008 WRITE_ALLOW_O / READ_ALLOW_O  out  1 each  logger access permitted.
REQ-009 WRITE_PTR_I / READ_PTR_I  in  $clog2(DEPTH) each  logger addresses.
REQ-010 DMEM_I  in  WIDTH  logger write data; DMEM_O  out  WIDTH  logger read data.
REQ-011 HOST_LOCK_I  in  1  host freezes memory for readout.
REQ-012 HOST_REQ_I / HOST_WE_I  in  1 each  host access request / write select.
REQ-013 HOST_ADDR_I  in  $clog2(DEPTH); HOST_WDATA_I  in  WIDTH.
REQ-014 HOST_ACK_O  out  1; HOST_RDATA_O  out  WIDTH.
REQ-015 PARITY_ERR_O  out  1  sticky parity error.

Function
REQ-016 Slot counter SHALL count 0..TURN_DIV-1 and wrap to 0; FSM states: LOG (count 0), HOST (count 1), IDLE (other counts).
REQ-017 RW_TURN_O SHALL be registered, high exactly one cycle per period, during LOG.
REQ-018 On the edge entering LOG, DMEM_O SHALL load mem[READ_PTR_I]; DMEM_O holds at all other times (valid throughout RW_TURN_O).
REQ-019 On the edge leaving LOG, if WRITE_I=1 and lock_q=0, mem[WRITE_PTR_I] SHALL load DMEM_I.
REQ-020 Same-address logger read and write in one period SHALL return old data (read precedes write).
REQ-021 lock_q SHALL be HOST_LOCK_I registered once; WRITE_ALLOW_O = READ_ALLOW_O = !lock_q.
REQ-022 Logger writes with lock_q=1 SHALL be dropped; RW_TURN_O keeps toggling regardless of lock.
REQ-023 Host access SHALL be served only in HOST when HOST_REQ_I=1 at that cycle; requests elsewhere wait for the next HOST slot; HOST_REQ_I held until ack.
REQ-024 Host read: HOST_RDATA_O = mem[HOST_ADDR_I], HOST_ACK_O pulsed one cycle, both on the edge leaving HOST.
REQ-025 Host write SHALL update memory only if lock_q=1; otherwise ignored; HOST_ACK_O pulses either way.
REQ-026 HOST_RDATA_O holds between acks; HOST_ACK_O never high two consecutive cycles.
REQ-027 Pointers SHALL be used modulo DEPTH; no out-of-range access.

Reset
REQ-028 Async reset SHALL clear slot counter to 0 (state LOG on release), RW_TURN_O=0, DMEM_O=0, HOST_RDATA_O=0, HOST_ACK_O=0, lock_q=0 (allows=1), PARITY_ERR_O=0.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset mid-access SHALL abort it: no memory write, no ack.
REQ-031 First RW_TURN_O SHALL occur in the first cycle after reset release.

Configuration
REQ-032 Macro TRB_MEM_PARITY_EN defined: each word SHALL store WIDTH+1 bits with even parity over data; every logger or host read with mismatch sets PARITY_ERR_O until reset.
REQ-033 Macro undefined: memory WIDTH bits, no parity logic, PARITY_ERR_O tied 0.

Verification
REQ-034 Reset release, TURN_DIV=4 -> RW_TURN_O high cycles 0,4,8,...; allows=1; all outputs 0.
REQ-035 WRITE_I=1, WRITE_PTR_I=5, DMEM_I=0xA5 in LOG; next period READ_PTR_I=5 -> DMEM_O=0xA5 during RW_TURN_O.
REQ-036 Same period WRITE_PTR_I=READ_PTR_I=3, old 0x11, new 0x22 -> DMEM_O=0x11 that period, 0x22 next.
REQ-037 HOST_LOCK_I=1 -> allows 0 next cycle; logger WRITE_I=1 addr 7 dropped; host write addr 7 0x5A acked; host read addr 7 -> 0x5A.
REQ-038 HOST_REQ_I asserted at count 2 -> ack at leaving next HOST slot (4 cycles later); host write without lock -> ack, memory unchanged.
REQ-039 TRB_MEM_PARITY_EN defined, parity bit of word 2 forced flipped -> host read addr 2 sets PARITY_ERR_O, stays 1 until RST_NI low.
